// File: rtl/client_req_fifo.sv
// client_req_fifo: small request FIFO between an upstream requester and an
// arbiter client port. Entries are {addr, read, wdata, tag}. The head entry is
// presented to the arbiter, and client_req is held until the arbiter grants
// it (client_bsy=0). in_bsy and client_req are decoded from the registered
// occupancy only. A push into an empty FIFO becomes visible one cycle later.
// Optional feature: define CLIENT_REQ_FIFO_STATS_EN to add the acc_cnt and
// stall_cnt statistics outputs.
module client_req_fifo #(
    parameter int W     = 16,
    parameter int AW    = 10,
    parameter int TW    = 4,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  logic [AW-1:0] in_addr,
    input  logic          in_read,
    input  logic [W-1:0]  in_wdata,
    input  logic [TW-1:0] in_tag,
    output logic          in_bsy,
    output logic          client_req,
    output logic [AW-1:0] client_addr,
    output logic          client_read,
    output logic [W-1:0]  client_wdata,
    output logic [TW-1:0] client_tag,
    input  logic          client_bsy,
    output logic [CW-1:0] level
`ifdef CLIENT_REQ_FIFO_STATS_EN
    ,
    output logic [15:0]   acc_cnt,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = AW + 1 + W + TW;

    // Entry layout, MSB first: addr, read flag, write data, tag.
    function automatic logic [EW-1:0] pack_entry(
        input logic [AW-1:0] addr,
        input logic          rd,
        input logic [W-1:0]  wdata,
        input logic [TW-1:0] tag
    );
        return {addr, rd, wdata, tag};
    endfunction

    logic [EW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] level_r;

    logic          full_s;
    logic          nonempty_s;
    logic          push_s;
    logic          pop_s;
    logic [EW-1:0] head_s;

    // Flow-control decode from registered occupancy and handshake qualification.
    always_comb begin
        full_s     = (level_r == CW'(DEPTH));
        nonempty_s = (level_r != {CW{1'b0}});
        push_s     = in_vld & ~full_s;
        pop_s      = nonempty_s & ~client_bsy;
        head_s     = mem_r[rd_ptr_r];
    end

    // Entry storage: cleared on reset, written at the write pointer on push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= pack_entry(in_addr, in_read, in_wdata, in_tag);
        end
    end

    // Pointers wrap naturally modulo DEPTH; level tracks push/pop balance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + CW'(1);
                2'b01:   level_r <= level_r - CW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Output decode: head entry fields and status, all from registered state.
    always_comb begin
        in_bsy       = full_s;
        client_req   = nonempty_s;
        level        = level_r;
        client_tag   = head_s[TW-1:0];
        client_wdata = head_s[TW +: W];
        client_read  = head_s[TW + W];
        client_addr  = head_s[EW-1 -: AW];
    end

`ifdef CLIENT_REQ_FIFO_STATS_EN
    logic [15:0] acc_cnt_r;
    logic [15:0] stall_cnt_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // Saturating counters of accepted pushes and arbiter-stalled cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_cnt_r   <= 16'd0;
            stall_cnt_r <= 16'd0;
        end else begin
            if (push_s) begin
                acc_cnt_r <= sat_inc(acc_cnt_r);
            end
            if (nonempty_s && client_bsy) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
        end
    end

    // Drive statistics outputs from their registers.
    always_comb begin
        acc_cnt   = acc_cnt_r;
        stall_cnt = stall_cnt_r;
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_client_req_fifo.sv
// Testbench for client_req_fifo: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_client_req_fifo;

    localparam int W     = 16;
    localparam int AW    = 10;
    localparam int TW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          rd;
        logic [W-1:0]  wd;
        logic [TW-1:0] tag;
    } ent_t;

    logic          clk;
    logic          rst_n;
    logic          in_vld;
    logic [AW-1:0] in_addr;
    logic          in_read;
    logic [W-1:0]  in_wdata;
    logic [TW-1:0] in_tag;
    logic          in_bsy;
    logic          client_req;
    logic [AW-1:0] client_addr;
    logic          client_read;
    logic [W-1:0]  client_wdata;
    logic [TW-1:0] client_tag;
    logic          client_bsy;
    logic [CW-1:0] level;
`ifdef CLIENT_REQ_FIFO_STATS_EN
    logic [15:0]   acc_cnt;
    logic [15:0]   stall_cnt;
`endif

    client_req_fifo #(.W(W), .AW(AW), .TW(TW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vld       (in_vld),
        .in_addr      (in_addr),
        .in_read      (in_read),
        .in_wdata     (in_wdata),
        .in_tag       (in_tag),
        .in_bsy       (in_bsy),
        .client_req   (client_req),
        .client_addr  (client_addr),
        .client_read  (client_read),
        .client_wdata (client_wdata),
        .client_tag   (client_tag),
        .client_bsy   (client_bsy),
        .level        (level)
`ifdef CLIENT_REQ_FIFO_STATS_EN
        ,
        .acc_cnt      (acc_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    bit   armed       = 1'b0;
    bit   clean       = 1'b1;
    ent_t exp_q[$];
    int   m_acc       = 0;
    int   m_stall     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard: compare DUT outputs with the model, then advance the
    // model by the handshakes the upcoming rising edge will perform.
    always @(negedge clk) begin
        int sz;
        bit do_push;
        bit do_pop;
        ent_t e;
        if (armed) begin
            sz = exp_q.size();
            chk("level", 32'(level), 32'(sz));
            chk("in_bsy", 32'(in_bsy), 32'(sz == DEPTH));
            chk("client_req", 32'(client_req), 32'(sz != 0));
            if (sz != 0) begin
                chk("client_addr", 32'(client_addr), 32'(exp_q[0].addr));
                chk("client_read", 32'(client_read), 32'(exp_q[0].rd));
                chk("client_wdata", 32'(client_wdata), 32'(exp_q[0].wd));
                chk("client_tag", 32'(client_tag), 32'(exp_q[0].tag));
            end else if (clean) begin
                chk("reset_data", {client_addr, client_read, client_wdata, client_tag}, 32'd0);
            end
`ifdef CLIENT_REQ_FIFO_STATS_EN
            chk("acc_cnt", 32'(acc_cnt), 32'(m_acc));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
        end
        if (rst_n !== 1'b1) begin
            exp_q.delete();
            clean   = 1'b1;
            m_acc   = 0;
            m_stall = 0;
        end else begin
            sz      = exp_q.size();
            do_push = (in_vld === 1'b1) && (sz < DEPTH);
            do_pop  = (sz > 0) && (client_bsy === 1'b0);
            if (sz > 0 && client_bsy === 1'b1 && m_stall < 65535) m_stall++;
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                e.addr = in_addr;
                e.rd   = in_read;
                e.wd   = in_wdata;
                e.tag  = in_tag;
                exp_q.push_back(e);
                clean = 1'b0;
                if (m_acc < 65535) m_acc++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Upstream-style push: hold the request until the FIFO accepts it.
    task automatic send(input logic [AW-1:0] a);
        bit acc;
        int n;
        in_vld   = 1'b1;
        in_addr  = a;
        in_read  = 1'($urandom);
        in_wdata = 16'($urandom);
        in_tag   = 4'($urandom);
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = (in_bsy === 1'b0);
            step();
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    int streamed_bsy = 0;

    initial begin
        rst_n      = 1'b0;
        in_vld     = 1'b0;
        in_addr    = '0;
        in_read    = 1'b0;
        in_wdata   = '0;
        in_tag     = '0;
        client_bsy = 1'b1;
        step();
        armed = 1'b1;
        repeat (4) step();
        rst_n = 1'b1;
        step();

        // Fill with the arbiter stalled, then offer a 5th request.
        for (int a = 1; a <= 4; a++) send(10'(a));
        in_addr = 10'd5;
        repeat (3) step();
        in_vld = 1'b0;
        step();

        // Drain from full.
        client_bsy = 1'b0;
        repeat (5) step();

        // Streaming with the arbiter always granting.
        for (int a = 33; a <= 47; a++) begin
            send(10'(a));
            if (in_bsy === 1'b1) streamed_bsy++;
        end
        in_vld = 1'b0;
        repeat (2) step();
        chk("stream_in_bsy", 32'(streamed_bsy), 32'd0);

        // Mid-operation reset with a coinciding push, then a fresh push.
        client_bsy = 1'b1;
        for (int a = 20; a < 23; a++) send(10'(a));
        rst_n   = 1'b0;
        in_addr = 10'd30;
        step();
        rst_n = 1'b1;
        send(10'd9);
        in_vld = 1'b0;
        repeat (2) step();
        client_bsy = 1'b0;
        repeat (2) step();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            in_vld     = ($urandom_range(0, 9) < 6);
            in_addr    = 10'($urandom);
            in_read    = 1'($urandom);
            in_wdata   = 16'($urandom);
            in_tag     = 4'($urandom);
            client_bsy = ($urandom_range(0, 9) < 5);
            rst_n      = ($urandom_range(0, 79) != 0);
            step();
        end
        in_vld = 1'b0;
        rst_n  = 1'b1;

`ifdef CLIENT_REQ_FIFO_STATS_EN
        // Statistics: six pushes, stall for a while, then a saturating stall.
        rst_n      = 1'b0;
        client_bsy = 1'b1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send(10'(i));
        in_vld = 1'b0;
        client_bsy = 1'b0;
        repeat (2) step();
        client_bsy = 1'b1;
        send(10'd4);
        send(10'd5);
        in_vld = 1'b0;
        repeat (10) step();
        repeat (65600) step();
`endif

        client_bsy = 1'b0;
        repeat (6) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/client_req_fifo.md
CLIENT_REQ_FIFO -- requirements
Module: client_req_fifo

Interface
REQ-001 The module SHALL have the following parameters, one per line: name, default, meaning.
- W, 16, write-data width.
- AW, 10, address width.
- TW, 4, tag width.
- DEPTH, 4, entry count; a power of 2, at least 2.
- CW = $clog2(DEPTH)+1, derived level width.
REQ-002 The module SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock.
- rst_n, in, 1, reset; synchronous, active-low.
- in_vld, in, 1, upstream request valid.
- in_addr, in, AW, request address.
- in_read, in, 1, 1 = read, 0 = write.
- in_wdata, in, W, write data.
- in_tag, in, TW, request tag.
- in_bsy, out, 1, upstream stall.
- client_req, out, 1, request to the arbiter client port.
- client_addr, out, AW, head-entry address.
- client_read, out, 1, head-entry read flag.
- client_wdata, out, W, head-entry write data.
- client_tag, out, TW, head-entry tag.
- client_bsy, in, 1, arbiter has not granted this client.
- level, out, CW, current occupancy.
REQ-003 All inputs SHALL be sampled on the rising edge of clk, and all state SHALL update only on that edge.

Function
REQ-004 A push SHALL occur in a cycle where in_vld=1 and in_bsy=0, storing {in_addr, in_read, in_wdata, in_tag} at the write pointer.
REQ-005 A pop SHALL occur in a cycle where client_req=1 and client_bsy=0, advancing the read pointer.
REQ-006 in_bsy SHALL equal (level==DEPTH), decoded from registered state only, with no combinational path from client_bsy or in_vld.
REQ-007 client_req SHALL equal (level!=0), decoded from registered state only, with no combinational path from in_vld.
REQ-008 client_addr, client_read, client_wdata and client_tag SHALL present the head (oldest) entry and SHALL remain stable while client_req=1 and client_bsy=1.
REQ-009 Latency SHALL be 1 cycle: a push into an empty FIFO at edge N SHALL raise client_req after edge N; there is no same-cycle bypass.
REQ-010 level SHALL increment on a push-only cycle, decrement on a pop-only cycle, and hold on a simultaneous push+pop or on an idle cycle.
REQ-011 A simultaneous push and pop SHALL be legal at any level from 1 to DEPTH-1; at level DEPTH a push is blocked by in_bsy; at level 0 a pop is impossible.
REQ-012 The read and write pointers SHALL be log2(DEPTH) bits wide and SHALL wrap modulo DEPTH with no gap.
REQ-013 Entries SHALL be delivered in strict push order, and no entry SHALL be duplicated or dropped.
REQ-014 in_vld=1 while in_bsy=1 SHALL cause no state change; upstream holds its data.

Reset
REQ-015 While rst_n=0 at a clk edge, level, both pointers and all storage entries SHALL be cleared to 0.
REQ-016 After reset: client_req=0, in_bsy=0, level=0, and client_addr, client_read, client_wdata and client_tag SHALL all be 0.
REQ-017 Reset asserted mid-operation SHALL discard all queued entries at that edge, with no pop reported.
REQ-018 Any push or pop coinciding with a reset edge SHALL be ignored.

Configuration
REQ-019 Macro CLIENT_REQ_FIFO_STATS_EN, when defined, SHALL add two outputs: acc_cnt[15:0], the number of accepted pushes, and stall_cnt[15:0], the number of cycles with client_req=1 and client_bsy=1.
REQ-020 Both counters SHALL saturate at 16'hFFFF and SHALL reset to 0.
REQ-021 With CLIENT_REQ_FIFO_STATS_EN undefined, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-022 Reset then idle: rst_n low for 5 cycles -> client_req=0, in_bsy=0, level=0, all data outputs 0.
REQ-023 Fill with client_bsy=1: push addrs 1,2,3,4 on consecutive cycles -> level reaches 4 and in_bsy=1 on the cycle after the 4th push; a 5th in_vld is held off; client_addr stays 1.
REQ-024 Drain: from full, set client_bsy=0 for 4 cycles -> client_addr sequence 1,2,3,4, level 4,3,2,1,0, client_req low after the 4th pop.
REQ-025 Streaming: in_vld=1 continuously with addrs 33..47 and client_bsy=0 -> level settles at 1, every address is delivered once in order, and in_bsy is never 1.
REQ-026 Mid-operation reset: level=3, assert rst_n=0 for one edge -> level=0, client_req=0, and the next push of addr 9 appears at client_addr=9 one cycle later.
REQ-027 Stats (macro defined): 6 pushes and client_bsy=1 for 10 cycles with client_req=1 -> acc_cnt=6, stall_cnt=10; forced long stall -> stall_cnt holds at 16'hFFFF.
